fwd_bypass_net: RTL

FWD_BYPASS_NET -- requirements
Module: fwd_bypass_net

---
 rtl/fwd_bypass_net.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fwd_bypass_net.sv
// fwd_bypass_net: operand bypass network between the writeback ports and the
// dispatch slots. A shallow writeback history lets sources that were renamed
// just before their producer retired still catch the result.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             pipeline flush: kills all hits, drops history, skips capture
//   wb_valid/tag/data per-port writeback (port p at [p*W +: W])
//   dis_valid         per-slot dispatch valid
//   dis_rs_need/tag   per-source need + ROB tag, source s = 2*slot + {rs1:0, rs2:1}
//   fwd_hit/src/age/data  combinational bypass result per source (zero on miss)
//   multi_hit_err     sticky: some source saw two matches at the same age
//   err_cnt           saturating count of multi-hit cycles
module fwd_bypass_net #(
    parameter int unsigned NWB  = 3,
    parameter int unsigned NDIS = 2,
    parameter int unsigned TAGW = 6,
    parameter int unsigned XLEN = 32,
    parameter int unsigned HIST = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       flush,
    input  logic [NWB-1:0]                             wb_valid,
    input  logic [NWB*TAGW-1:0]                        wb_tag,
    input  logic [NWB*XLEN-1:0]                        wb_data,
    input  logic [NDIS-1:0]                            dis_valid,
    input  logic [NDIS*2-1:0]                          dis_rs_need,
    input  logic [NDIS*2*TAGW-1:0]                     dis_rs_tag,
    output logic [NDIS*2-1:0]                          fwd_hit,
    output logic [NDIS*2*((NWB > 1) ? $clog2(NWB) : 1)-1:0] fwd_src,
    output logic [NDIS*2*$clog2(HIST+1)-1:0]           fwd_age,
    output logic [NDIS*2*XLEN-1:0]                     fwd_data,
    output logic                                       multi_hit_err,
    output logic [7:0]                                 err_cnt
);

    localparam int unsigned NSRC = NDIS * 2;
    localparam int unsigned SW   = (NWB > 1) ? $clog2(NWB) : 1;
    localparam int unsigned AW   = $clog2(HIST + 1);
    localparam int unsigned NAGE = HIST + 1;

    logic [NWB-1:0]      hist_valid [HIST];
    logic [NWB*TAGW-1:0] hist_tag   [HIST];
    logic [NWB*XLEN-1:0] hist_data  [HIST];

    logic [NWB-1:0]      cand_valid [NAGE];
    logic [NWB*TAGW-1:0] cand_tag   [NAGE];
    logic [NWB*XLEN-1:0] cand_data  [NAGE];

    logic multi_hit_c;

    // Writeback history: stage 0 is last cycle's writebacks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < HIST; k++) begin
                hist_valid[k] <= '0;
                hist_tag[k]   <= '0;
                hist_data[k]  <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < HIST; k++) begin
                hist_valid[k] <= '0;
            end
        end else begin
            hist_valid[0] <= wb_valid;
            hist_tag[0]   <= wb_tag;
            hist_data[0]  <= wb_data;
            for (int k = 1; k < HIST; k++) begin
                hist_valid[k] <= hist_valid[k-1];
                hist_tag[k]   <= hist_tag[k-1];
                hist_data[k]  <= hist_data[k-1];
            end
        end
    end

    // Candidate set indexed by age: age 0 is the live writeback bus.
    always_comb begin
        cand_valid[0] = wb_valid;
        cand_tag[0]   = wb_tag;
        cand_data[0]  = wb_data;
        for (int k = 0; k < HIST; k++) begin
            cand_valid[k+1] = hist_valid[k];
            cand_tag[k+1]   = hist_tag[k];
            cand_data[k+1]  = hist_data[k];
        end
    end

    // Per-source priority select: scan youngest age first, lowest port first,
    // so the first match found is the winner. A second match within one age
    // flags a multi-hit.
    always_comb begin : resolve
        logic active;
        logic found;
        logic seen;
        fwd_hit     = '0;
        fwd_src     = '0;
        fwd_age     = '0;
        fwd_data    = '0;
        multi_hit_c = 1'b0;
        active      = 1'b0;
        found       = 1'b0;
        seen        = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            active = dis_valid[s/2] & dis_rs_need[s] & ~flush;
            found  = 1'b0;
            for (int a = 0; a < NAGE; a++) begin
                seen = 1'b0;
                for (int p = 0; p < NWB; p++) begin
                    if (active && cand_valid[a][p] &&
                        (cand_tag[a][p*TAGW +: TAGW] == dis_rs_tag[s*TAGW +: TAGW])) begin
                        if (seen) begin
                            multi_hit_c = 1'b1;
                        end
                        seen = 1'b1;
                        if (!found) begin
                            found                   = 1'b1;
                            fwd_src[s*SW +: SW]     = SW'(p);
                            fwd_age[s*AW +: AW]     = AW'(a);
                            fwd_data[s*XLEN +: XLEN] = cand_data[a][p*XLEN +: XLEN];
                        end
                    end
                end
            end
            fwd_hit[s] = found;
        end
    end

    // Sticky error flag and saturating multi-hit cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi_hit_err <= 1'b0;
            err_cnt       <= 8'd0;
        end else if (multi_hit_c) begin
            multi_hit_err <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
